// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch sequencer states: issue request, await data, hold instruction, trapped.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    // Sequential PC increment for fall-through instructions.
    localparam logic [31:0] PC_STEP   = 32'd4;

    // JALR targets have bit 0 forced low before the alignment check.
    localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: priority mux over JALR, JAL, taken branch and fall-through,
// plus the 4-byte alignment check on the chosen target.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // JALR wins over JAL, which wins over a taken branch; branch_taken only matters for branches.
    always_comb begin
        if (is_jalr) begin
            next_pc = (rs1_data + imm) & JALR_MASK;
        end else if (is_jal || (is_branch && branch_taken)) begin
            next_pc = pc + imm;
        end else begin
            next_pc = pc + PC_STEP;
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, issues one memory request
// at a time, holds the returned word for the core, and commits the next PC
// (or traps on a misaligned target) when the core retires the instruction.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ack,
    input  logic        branch_taken,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        misalign_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         imem_req_q, imem_req_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         fault_q, fault_d;

    logic [31:0]  next_pc;
    logic         next_misaligned;

    next_pc_calc u_next_pc_calc (
        .pc           (pc_q),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    // Next-state and next-output decode; imem_req is registered, so it rises one cycle after reset release.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;

        case (state_q)
            REQ: begin
                imem_req_d = 1'b1;
                if (imem_req_q && imem_ready) begin
                    imem_req_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                imem_req_d = 1'b0;
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = VALID;
                end
            end
            VALID: begin
                if (instr_ack) begin
                    instr_valid_d = 1'b0;
                    if (next_misaligned) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d       = next_pc;
                        imem_req_d = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            FAULT: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                fault_d       = 1'b1;
            end
            default: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                fault_d       = 1'b1;
                state_d       = FAULT;
            end
        endcase
    end

    // State and registered outputs; reset returns everything to the reset PC with nothing in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign misalign_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model plus
// directed and randomized instruction sequences.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    localparam int PH_REQ   = 0;
    localparam int PH_OUT   = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ack = 1'b0;
    logic        branch_taken = 1'b0;
    logic        is_branch = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic        misalign_fault;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ack      (instr_ack),
        .branch_taken   (branch_taken),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    // Reference model state: where the fetch stage must be, in transaction terms.
    int          m_phase = PH_REQ;
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_ipc   = 32'h0;
    int          m_idle  = 0;
    logic        seen_req = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next-PC rule written straight from the control-flow definition.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] immv,
                                             input logic [31:0] rs1v, input logic br, input logic bt,
                                             input logic jal, input logic jalr);
        logic [31:0] t;
        if (jalr) begin
            t = rs1v + immv;
            return (t >> 1) << 1;
        end
        if (jal) return pc + immv;
        if (br && bt) return pc + immv;
        return pc + 32'd4;
    endfunction

    // Model advances on each clock using the bus handshakes seen on the interface.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= PH_REQ;
            m_pc    <= RST_PC;
            m_idle  <= 0;
        end else begin
            case (m_phase)
                PH_REQ: begin
                    m_idle <= seen_req ? 0 : m_idle + 1;
                    if (seen_req && imem_ready) m_phase <= PH_OUT;
                end
                PH_OUT: begin
                    if (imem_rvalid) begin
                        m_instr <= imem_rdata;
                        m_ipc   <= m_pc;
                        m_phase <= PH_HOLD;
                    end
                end
                PH_HOLD: begin
                    if (instr_ack) begin
                        if ((ref_next(m_pc, imm, rs1_data, is_branch, branch_taken, is_jal, is_jalr) & 32'h3) != 32'h0) begin
                            m_phase <= PH_FAULT;
                        end else begin
                            m_pc    <= ref_next(m_pc, imm, rs1_data, is_branch, branch_taken, is_jal, is_jalr);
                            m_phase <= PH_REQ;
                        end
                    end
                end
                default: m_phase <= PH_FAULT;
            endcase
        end
    end

    // Compare process: checks every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        seen_req = imem_req;
        if (rst) begin
            checkOutput("rst_req", imem_req, 32'h0);
            checkOutput("rst_addr", imem_addr, RST_PC);
            checkOutput("rst_valid", instr_valid, 32'h0);
            checkOutput("rst_instr", instr, 32'h0);
            checkOutput("rst_ipc", instr_pc, 32'h0);
            checkOutput("rst_fault", misalign_fault, 32'h0);
        end else begin
            checkOutput("addr_is_pc", imem_addr, m_pc);
            checkOutput("instr_valid", instr_valid, (m_phase == PH_HOLD) ? 32'h1 : 32'h0);
            checkOutput("fault", misalign_fault, (m_phase == PH_FAULT) ? 32'h1 : 32'h0);
            if (m_phase != PH_REQ) checkOutput("req_idle", imem_req, 32'h0);
            if (m_phase == PH_REQ) checkOutput("req_live", (m_idle > 2) ? 32'h1 : 32'h0, 32'h0);
            if (m_phase == PH_HOLD) begin
                checkOutput("instr", instr, m_instr);
                checkOutput("instr_pc", instr_pc, m_ipc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic randomCtrl();
        is_branch    = 1'($urandom);
        branch_taken = 1'($urandom);
        is_jal       = 1'($urandom);
        is_jalr      = 1'($urandom);
        imm          = $urandom;
        rs1_data     = $urandom;
    endtask

    // Run one instruction through the stage; flags = {jalr, jal, branch, taken}.
    task automatic applyStimulus(input int rqd, input int rvd, input int akd, input logic [3:0] flags,
                                 input logic [31:0] immv, input logic [31:0] rs1v, input logic [31:0] word,
                                 output logic [31:0] req_addr, output logic [31:0] got_ipc,
                                 output logic [31:0] got_instr, output logic [31:0] next_addr);
        int guard;
        guard = 0;
        while (!imem_req && guard < 8) begin
            imem_ready  = 1'($urandom);
            imem_rvalid = 1'($urandom);
            instr_ack   = 1'($urandom);
            randomCtrl();
            step();
            guard++;
        end
        if (!imem_req) begin
            checkOutput("req_timeout", imem_req, 32'h1);
            req_addr  = imem_addr;
            got_ipc   = instr_pc;
            got_instr = instr;
            next_addr = imem_addr;
            return;
        end
        req_addr = imem_addr;
        for (int i = 0; i < rqd; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'($urandom);
            instr_ack   = 1'($urandom);
            randomCtrl();
            step();
            checkOutput("addr_stable", imem_addr, req_addr);
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'($urandom);
        for (int i = 0; i < rvd; i++) begin
            imem_rvalid = 1'b0;
            instr_ack   = 1'($urandom);
            randomCtrl();
            step();
            checkOutput("no_early_valid", instr_valid, 32'h0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        got_ipc     = instr_pc;
        got_instr   = instr;
        imem_rvalid = 1'($urandom);
        imem_rdata  = $urandom;
        for (int i = 0; i < akd; i++) begin
            instr_ack = 1'b0;
            randomCtrl();
            step();
        end
        instr_ack    = 1'b1;
        is_jalr      = flags[3];
        is_jal       = flags[2];
        is_branch    = flags[1];
        branch_taken = flags[0];
        imm          = immv;
        rs1_data     = rs1v;
        step();
        instr_ack  = 1'b0;
        imem_ready = 1'b0;
        randomCtrl();
        checkOutput("req_after_ack", imem_req, (m_phase == PH_FAULT) ? 32'h0 : 32'h1);
        next_addr = imem_addr;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    logic [32*4-1:0] seq_exp;
    logic [31:0] ra, ipc, iw, na;

    // Directed scenarios followed by a randomized run.
    initial begin
        seq_exp = {32'h100, 32'h104, 32'h108, 32'h10C};
        step();
        step();
        step();
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 4'b0000, $urandom, $urandom, 32'hA000_0000 + k, ra, ipc, iw, na);
            checkOutput("seq_req", ra, seq_exp[32*(3-k) +: 32]);
            checkOutput("seq_ipc", ipc, seq_exp[32*(3-k) +: 32]);
            checkOutput("seq_instr", iw, 32'hA000_0000 + k);
            checkOutput("seq_next", na, seq_exp[32*(2-k) +: 32]);
        end

        applyStimulus(1, 0, 1, 4'b0100, 32'h0000_00F4, $urandom, 32'h1, ra, ipc, iw, na);
        checkOutput("jal_to_200", na, 32'h200);
        applyStimulus(0, 1, 0, 4'b0011, 32'hFFFF_FFF0, $urandom, 32'h2, ra, ipc, iw, na);
        checkOutput("br_taken", na, 32'h1F0);
        applyStimulus(0, 0, 0, 4'b0100, 32'h0000_0010, $urandom, 32'h3, ra, ipc, iw, na);
        checkOutput("jal_back", na, 32'h200);
        applyStimulus(0, 0, 2, 4'b0010, 32'hFFFF_FFF0, $urandom, 32'h4, ra, ipc, iw, na);
        checkOutput("br_not_taken", na, 32'h204);
        applyStimulus(0, 0, 0, 4'b0100, 32'hFFFF_FFFC, $urandom, 32'h5, ra, ipc, iw, na);
        checkOutput("jal_neg", na, 32'h200);
        applyStimulus(0, 0, 0, 4'b0001, 32'hFFFF_FFF0, $urandom, 32'h6, ra, ipc, iw, na);
        checkOutput("taken_not_branch", na, 32'h204);
        applyStimulus(0, 0, 0, 4'b1100, 32'h0000_0003, 32'h0000_1001, 32'h7, ra, ipc, iw, na);
        checkOutput("jalr_wins", na, 32'h1004);

        applyStimulus(5, 4, 0, 4'b0000, $urandom, $urandom, 32'hDEAD_BEEF, ra, ipc, iw, na);
        checkOutput("slow_req", ra, 32'h1004);
        checkOutput("slow_instr", iw, 32'hDEAD_BEEF);
        checkOutput("slow_ipc", ipc, 32'h1004);
        checkOutput("slow_next", na, 32'h1008);

        applyStimulus(0, 0, 0, 4'b1000, 32'h0000_000C, 32'hFFFF_FFF0, 32'h8, ra, ipc, iw, na);
        checkOutput("to_top", na, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 4'b0000, $urandom, $urandom, 32'h9, ra, ipc, iw, na);
        checkOutput("wrap", na, 32'h0);

        // Reset while a request is outstanding; the late data must be dropped.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        step();
        imem_rvalid = 1'b0;
        checkOutput("stray_valid", instr_valid, 32'h0);
        checkOutput("stray_addr", imem_addr, RST_PC);
        step();
        checkOutput("stray_valid2", instr_valid, 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] ri;
            ri = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 24) == 0) ri = ri | 32'h2;
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          4'($urandom), ri, $urandom & 32'hFFFF_FFFD, $urandom, ra, ipc, iw, na);
            if (m_phase == PH_FAULT) begin
                checkOutput("rand_fault", misalign_fault, 32'h1);
                checkOutput("rand_fault_pc", na, ra);
                pulseReset();
            end
        end

        applyStimulus(0, 0, 0, 4'b0000, $urandom, $urandom, 32'hB, ra, ipc, iw, na);
        applyStimulus(0, 0, 0, 4'b1000, 32'h0000_0002, 32'h0000_1000, 32'hC, ra, ipc, iw, na);
        for (int k = 0; k < 4; k++) begin
            instr_ack   = 1'($urandom);
            imem_ready  = 1'($urandom);
            imem_rvalid = 1'($urandom);
            randomCtrl();
            step();
            checkOutput("jalr_fault", misalign_fault, 32'h1);
            checkOutput("fault_no_req", imem_req, 32'h0);
            checkOutput("fault_no_valid", instr_valid, 32'h0);
            checkOutput("fault_pc_held", imem_addr, ra);
        end
        pulseReset();
        checkOutput("post_fault_clear", misalign_fault, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #400000;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle instruction fetch stage with the program counter register, sitting upstream of decode and the branch comparator. It issues one instruction-memory request at a time and presents the returned word with its PC. It accepts the resolved control-flow outcome (branch_taken plus jump flags and operands) when the instruction is retired. It then computes and commits the next PC, trapping misaligned targets.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; equals current PC
- imem_ready  in  1  memory accepts request this cycle (imem_req && imem_ready = handshake)
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  32  captured instruction word
- instr_pc  out  32  PC of instr
- instr_ack  in  1  core retires instr this cycle; control inputs below sampled now
- branch_taken  in  1  comparator result for current instruction
- is_branch  in  1  current instruction is a conditional branch
- is_jal  in  1  current instruction is JAL
- is_jalr  in  1  current instruction is JALR
- imm  in  32  sign-extended immediate of current instruction
- rs1_data  in  32  rs1 value (JALR base)
- misalign_fault  out  1  sticky: next-PC target not 4-byte aligned

## Operation
- FSM states: REQ, WAIT, VALID, FAULT.
- Reset: pc=RESET_PC, state=REQ, imem_req=0 during reset, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign_fault=0.
- REQ: imem_req=1, imem_addr=pc held stable until imem_ready; on imem_ready -> WAIT.
- WAIT: imem_req=0; on imem_rvalid capture instr<=imem_rdata, instr_pc<=pc -> VALID.
- VALID: instr_valid=1; stays until instr_ack. On instr_ack compute next, priority order:
  - is_jalr: (rs1_data+imm) & ~32'h1
  - is_jal: pc+imm
  - is_branch && branch_taken: pc+imm
  - otherwise: pc+4
- If next[1:0]!=0 -> FAULT, pc unchanged, misalign_fault=1. Otherwise pc<=next -> REQ.
- FAULT: terminal until rst; imem_req=0, instr_valid=0, misalign_fault=1.
- branch_taken ignored unless is_branch. All control inputs ignored unless state=VALID && instr_ack.
- imem_rvalid outside WAIT ignored. instr_ack outside VALID ignored.
- Only one outstanding request, no speculation or prefetch.
- Adds are modulo 2^32 and wrap silently (0xFFFF_FFFC+4 = 0x0000_0000).

## Timing
- All outputs registered or decoded from state only; no input-to-output combinational path.
- Minimum 3 cycles per instruction: REQ (ready same cycle), WAIT (rvalid next cycle), VALID (ack same cycle).
- imem_rvalid may arrive ≥1 cycle after handshake. Wait cycles in REQ/WAIT/VALID are unbounded.
- The new PC appears on imem_addr in the cycle after instr_ack.
- rst mid-operation (any state) returns to reset values immediately. A late imem_rvalid from a pre-reset request arriving in REQ is dropped.

## Structure
- Package fetch_pkg: state enum (REQ, WAIT, VALID, FAULT), PC_STEP=32'd4, JALR_MASK=32'hFFFF_FFFE.
- Sub-module next_pc_calc: combinational priority mux and adders producing next and misaligned. The FSM and registers live in fetch_unit.

## Test plan
- Reset with RESET_PC=0x100, ready/rvalid immediate, ack with no flags ×3 -> imem_addr sequence 0x100, 0x104, 0x108; instr_pc matches each.
- pc=0x200, is_branch=1, branch_taken=1, imm=0xFFFFFFF0 -> next fetch 0x1F0. Same with branch_taken=0 -> 0x204. branch_taken=1, is_branch=0 -> 0x204.
- is_jalr=1, is_jal=1, rs1_data=0x1001, imm=0x3 -> 0x1004 (JALR wins, bit0 cleared). is_jalr, rs1=0x1000, imm=0x2 -> FAULT, misalign_fault=1, imem_req stays 0.
- imem_ready low 5 cycles, then rvalid 4 cycles late -> imem_addr stable throughout, single capture, instr_valid only after rvalid.
- pc=0xFFFFFFFC, plain ack -> wraps to 0x0. Assert rst while in WAIT, then rvalid after release -> pc=RESET_PC, stray rvalid ignored, instr_valid=0.
